// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   state_t : responder FSM encoding (IDLE, WAIT, RESP)
//   CNT_W   : width of the latency counter
//   idx_w() : word-index width for a given array depth
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int CNT_W = 4;

   function automatic int idx_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32 word storage, byte-enabled synchronous write,
// combinational read, whole array cleared by the asynchronous reset.
//   clock, reset : rising-edge clock, asynchronous active-low clear
//   we, be       : write strobe and per-byte enables
//   idx          : word index shared by read and write
//   wdata, rdata : write data in, combinational read data out
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] wmask;
   logic [31:0] words [DEPTH];

   assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   assign rdata = words[idx];

   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      logic [31:0] word_q, word_d;
      assign word_d = (we && idx == AW'(i)) ? ((word_q & ~wmask) | (wdata & wmask)) : word_q;
      always_ff @(posedge clock or negedge reset)
         if (!reset) word_q <= 32'd0;
         else        word_q <= word_d;
      assign words[i] = word_q;
   end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: target end of the CPU load/store interface; one outstanding
// transaction, response LATENCY+1 edges after acceptance.
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (accepted only in IDLE)
//   req_wen/addr/wdata/be : store flag, byte address, store data, byte enables
//   resp_valid/resp_ready : response handshake
//   resp_rdata/resp_err   : load data (0 for stores/errors), access error flag
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        reset,
   input  logic        clock,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = idx_w(DEPTH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wen_q, wen_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       be_q, be_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;
   logic             bad, we;
   logic [31:0]      rd;

   assign bad        = (addr_q[1:0] != 2'b00) || ((addr_q >> (AW + 2)) != 32'd0);
   assign req_ready  = state_q == IDLE;
   assign resp_valid = state_q == RESP;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .clock (clock),
      .reset (reset),
      .we    (we),
      .be    (be_q),
      .idx   (addr_q[AW+1:2]),
      .wdata (wdata_q),
      .rdata (rd)
   );

   // Every request passes through WAIT; the commit fires once the counter
   // has run down to zero, so the response is uniformly LATENCY+1 edges out.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wen_d   = wen_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      we      = 1'b0;
      case (state_q)
         IDLE:
            if (req_valid) begin
               wen_d   = req_wen;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               be_d    = req_be;
               cnt_d   = CNT_W'(LATENCY);
               state_d = WAIT;
            end
         WAIT:
            if (cnt_q == '0) begin
               we      = wen_q && !bad;
               err_d   = bad;
               rdata_d = (wen_q || bad) ? 32'd0 : rd;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         RESP:
            if (resp_ready) begin
               rdata_d = 32'd0;
               err_d   = 1'b0;
               state_d = IDLE;
            end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         wen_q   <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wen_q   <= wen_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder (DEPTH=256, LATENCY=2).
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic        reset, clock;
   logic        req_valid, req_ready, req_wen;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   logic [31:0] mem_m [DEPTH];
   logic [32:0] sb [$];
   int          n_checks = 0;
   int          n_fail   = 0;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .reset      (reset),
      .clock      (clock),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wen    (req_wen),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_be     (req_be),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Model the transaction, drive it, and check latency, payload, backpressure
   // stability and the return to IDLE.
   task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold);
      logic        bad;
      logic [7:0]  idx;
      logic [32:0] exp;
      logic [31:0] rd0;
      logic        er0;
      int          w, cyc;
      idx = addr[9:2];
      bad = (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
      if (bad) exp = {1'b1, 32'd0};
      else if (wen) begin
         for (int b = 0; b < 4; b++) if (be[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
         exp = {1'b0, 32'd0};
      end else exp = {1'b0, mem_m[idx]};
      sb.push_back(exp);
      @(negedge clock);
      req_valid  = 1'b1;
      req_wen    = wen;
      req_addr   = addr;
      req_wdata  = wdata;
      req_be     = be;
      resp_ready = (hold == 0);
      w = 0;
      while (!req_ready && w < 40) begin
         @(negedge clock);
         w++;
      end
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      req_wen   = ~wen;
      req_addr  = ~addr;
      req_wdata = ~wdata;
      req_be    = ~be;
      cyc = 0;
      do begin
         @(posedge clock);
         #1;
         cyc++;
      end while (!resp_valid && cyc < 40);
      check("latency", 32'(cyc), 32'(LAT + 1));
      exp = sb.pop_front();
      check("rdata", resp_rdata, exp[31:0]);
      check("err", 32'(resp_err), 32'(exp[32]));
      rd0 = resp_rdata;
      er0 = resp_err;
      for (int h = 0; h < hold; h++) begin
         @(posedge clock);
         #1;
         check("bp_valid", 32'(resp_valid), 32'd1);
         check("bp_rdata", resp_rdata, rd0);
         check("bp_err", 32'(resp_err), 32'(er0));
         check("bp_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clock);
      #1;
      resp_ready = 1'b0;
      check("post_valid", 32'(resp_valid), 32'd0);
      check("post_req_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] a;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
      reset      = 1'b0;
      req_valid  = 1'b0;
      req_wen    = 1'b0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      req_be     = 4'd0;
      resp_ready = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
      reset = 1'b1;

      txn(1'b0, 32'h10, 32'h0, 4'hF, 0);
      txn(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 0);
      txn(1'b0, 32'h20, 32'h0, 4'h0, 0);
      txn(1'b1, 32'h20, 32'h00000011, 4'h1, 0);
      txn(1'b0, 32'h20, 32'h0, 4'hF, 0);
      check("model_bytemerge", mem_m[8], 32'hDEADBE11);
      txn(1'b0, 32'h22, 32'h0, 4'hF, 0);
      txn(1'b0, 32'h400, 32'h0, 4'hF, 0);
      txn(1'b1, 32'h22, 32'h12345678, 4'hF, 0);
      txn(1'b1, 32'h420, 32'h12345678, 4'hF, 0);
      txn(1'b0, 32'h00, 32'h0, 4'hF, 0);
      txn(1'b0, 32'h20, 32'h0, 4'hF, 0);
      txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0);
      txn(1'b0, 32'h20, 32'h0, 4'h0, 5);
      txn(1'b1, 32'h3FC, 32'hA5A5_5A5A, 4'hA, 3);
      txn(1'b0, 32'h3FC, 32'h0, 4'h0, 0);

      for (int k = 0; k < 24; k++) begin
         a = 32'($urandom_range(0, 15)) << 2;
         if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
         txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      end

      @(negedge clock);
      req_valid = 1'b1;
      req_wen   = 1'b1;
      req_addr  = 32'h30;
      req_wdata = 32'hCAFEF00D;
      req_be    = 4'hF;
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      check("midrst_in_wait", 32'(req_ready), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clock);
      check("midrst_hold_valid", 32'(resp_valid), 32'd0);
      reset = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'd0;
      txn(1'b0, 32'h30, 32'h0, 4'hF, 0);
      txn(1'b0, 32'h20, 32'h0, 4'hF, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
